// File: rtl/byte_pack_buffer.sv
// byte_pack_buffer: packs IN_W-bit bytes into RATIO-byte words and buffers them in a
// DEPTH-word FIFO. The read port is first-word fall-through and carries a byte-keep mask.
//
// Ports:
//   CLK_IN1, RESET_N        clock (rising edge), async active-low reset
//   in_valid/in_ready       byte stream handshake, in_data carries the byte
//   msb_first               byte order, latched when the first byte of a word is accepted
//   flush                   pulse: push the current partial word (zero padded)
//   out_valid/out_ready     word stream handshake, out_data/out_keep carry the word
//   level                   words held, output register included (0..DEPTH)
module byte_pack_buffer #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned RATIO  = 4,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                      CLK_IN1,
  input  logic                      RESET_N,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      msb_first,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IN_W*RATIO-1:0]     out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic [ADDR_W:0]           level
);

  localparam int unsigned OUT_W   = IN_W * RATIO;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned IDX_W   = $clog2(RATIO);
  localparam int unsigned LEVEL_W = ADDR_W + 1;
  localparam int unsigned MEM_W   = OUT_W + RATIO;

  localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(RATIO - 1);
  localparam logic [LEVEL_W-1:0] FullLvl = LEVEL_W'(DEPTH);

  // Packing state
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   pack_q, pack_d;
  logic [RATIO-1:0]   keep_q, keep_d;
  logic               order_q, order_d;
  logic               flush_pending_q, flush_pending_d;

  // FIFO state
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q;
  logic [RATIO-1:0]   out_keep_q;

  logic [MEM_W-1:0]   mem [DEPTH];

  logic               last_idx, level_full, accept, cur_order;
  logic [IDX_W-1:0]   lane;
  logic [OUT_W-1:0]   pack_merged;
  logic [RATIO-1:0]   keep_merged;
  logic               push_full, flush_req, push_partial, set_pending, push, pop, load;
  logic [LEVEL_W-1:0] ram_cnt;

  always_comb begin
    last_idx    = (idx_q == LastIdx);
    level_full  = (level_q == FullLvl);
    in_ready    = !flush_pending_q && (!last_idx || !level_full);
    accept      = in_valid && in_ready;
    // The order applies to the whole word: take it live for the first byte, latched after.
    cur_order   = (idx_q == '0) ? msb_first : order_q;
    lane        = cur_order ? (LastIdx - idx_q) : idx_q;

    pack_merged = pack_q;
    keep_merged = keep_q;
    if (accept) begin
      pack_merged[lane*IN_W +: IN_W] = in_data;
      keep_merged[lane]              = 1'b1;
    end

    push_full    = accept && last_idx;
    // A flush counts only if there is something to push; a completing byte absorbs it.
    flush_req    = flush && !push_full && !flush_pending_q && ((idx_q != '0) || accept);
    push_partial = !level_full && (flush_pending_q || flush_req);
    set_pending  = level_full && flush_req;
    push         = push_full || push_partial;

    pop     = out_valid_q && out_ready;
    // Words still in RAM, i.e. not yet moved into the output register.
    ram_cnt = level_q - LEVEL_W'(out_valid_q);
    load    = (ram_cnt != '0) && (!out_valid_q || out_ready);
  end

  always_comb begin
    idx_d           = idx_q;
    pack_d          = pack_merged;
    keep_d          = keep_merged;
    order_d         = order_q;
    flush_pending_d = flush_pending_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    out_valid_d     = out_valid_q;

    if (accept && (idx_q == '0)) begin
      order_d = msb_first;
    end
    if (push) begin
      idx_d    = '0;
      pack_d   = '0;
      keep_d   = '0;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else if (accept) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (push_partial) begin
      flush_pending_d = 1'b0;
    end else if (set_pending) begin
      flush_pending_d = 1'b1;
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    level_d = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
  end

  always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q           <= '0;
      pack_q          <= '0;
      keep_q          <= '0;
      order_q         <= 1'b0;
      flush_pending_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      out_valid_q     <= 1'b0;
    end else begin
      idx_q           <= idx_d;
      pack_q          <= pack_d;
      keep_q          <= keep_d;
      order_q         <= order_d;
      flush_pending_q <= flush_pending_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      out_valid_q     <= out_valid_d;
    end
  end

  // RAM write port: data and keep stored side by side.
  always_ff @(posedge CLK_IN1) begin
    if (push) begin
      mem[wr_ptr_q] <= {keep_merged, pack_merged};
    end
  end

  // Synchronous read straight into the output register.
  always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
    if (!RESET_N) begin
      out_data_q <= '0;
      out_keep_q <= '0;
    end else if (load) begin
      {out_keep_q, out_data_q} <= mem[rd_ptr_q];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign level     = level_q;

endmodule

// File: tb/tb_byte_pack_buffer.sv
module tb_byte_pack_buffer;

  localparam int R = 4;
  localparam int ADDR_W = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, msb_first, flush, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [2:0]  level;

  byte_pack_buffer #(
    .IN_W   (8),
    .RATIO  (R),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK_IN1   (clk),
    .RESET_N   (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .level     (level)
  );

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    int          t;
  } word_t;

  // Reference model: bytes of the word in progress, its order, and the words held.
  word_t      wq[$];
  logic [7:0] cur_bytes[$];
  logic       ord;
  logic       pend;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word();
    word_t w;
    w.data = '0;
    w.keep = '0;
    for (int i = 0; i < cur_bytes.size(); i++) begin
      int ln;
      ln = ord ? (R - 1 - i) : i;
      w.data[ln*8 +: 8] = cur_bytes[i];
      w.keep[ln] = 1'b1;
    end
    w.t = ecount + 1;
    wq.push_back(w);
    cur_bytes.delete();
  endtask

  task automatic model_clear();
    wq.delete();
    cur_bytes.delete();
    ord  = 1'b0;
    pend = 1'b0;
  endtask

  // One clock: drive, check outputs at negedge, advance the model, return at posedge+1.
  task automatic step(input logic v, input logic [7:0] d, input logic m, input logic f,
                      input logic r);
    logic exp_rdy, exp_ov;
    int   size0;
    in_valid = v; in_data = d; msb_first = m; flush = f; out_ready = r;
    @(negedge clk);
    exp_rdy = !pend && (cur_bytes.size() != R - 1 || wq.size() < D);
    exp_ov  = (wq.size() > 0) && (wq[0].t < ecount);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    chk("level", level, wq.size());
    if (exp_ov) begin
      chk("out_data", out_data, wq[0].data);
      chk("out_keep", out_keep, wq[0].keep);
    end
    size0 = wq.size();
    if (exp_ov && r) void'(wq.pop_front());
    if (v && exp_rdy) begin
      if (cur_bytes.size() == 0) ord = m;
      cur_bytes.push_back(d);
    end
    if (cur_bytes.size() == R) begin
      push_word();
    end else if (pend) begin
      if (size0 < D) begin
        push_word();
        pend = 1'b0;
      end
    end else if (f && cur_bytes.size() > 0) begin
      if (size0 < D) push_word();
      else pend = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0; msb_first = 0; in_data = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; msb_first = 0; flush = 0; out_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", out_data, 32'h0);
    chk("reset_keep", out_keep, 4'h0);
    do_reset();

    // LSB-first word
    step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0); step(1, 8'h44, 0, 0, 0);
    chk("t1_not_yet_valid", out_valid, 1'b0);
    idle(1, 0);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'h44332211);
    chk("t1_keep", out_keep, 4'hf);
    chk("t1_level", level, 1);
    idle(2, 1);

    // MSB-first, order toggled mid-word
    step(1, 8'h11, 1, 0, 0); step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 1, 0, 0); step(1, 8'h44, 0, 0, 0);
    idle(1, 0);
    chk("t2_data", out_data, 32'h11223344);
    idle(2, 1);

    // Partial flush, then a flush with nothing to push
    step(1, 8'hAA, 0, 0, 0); step(1, 8'hBB, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    idle(1, 0);
    chk("t3_data", out_data, 32'h0000BBAA);
    chk("t3_keep", out_keep, 4'h3);
    step(0, 8'h00, 0, 1, 1);
    idle(2, 0);
    chk("t3_empty", level, 0);

    // Full buffer and back-pressure
    for (int i = 1; i <= 19; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'd20, 0, 0, 0);
    chk("t4_full_rdy", in_ready, 1'b0);
    chk("t4_full_lvl", level, 4);
    step(1, 8'd20, 0, 0, 1);
    step(1, 8'd20, 0, 0, 0);
    chk("t4_level_after", level, 4);
    idle(8, 1);

    // Flush while full
    for (int i = 0; i < 16; i++) step(1, 8'(i + 8'h40), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0); step(1, 8'hBB, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    chk("t5_pending_rdy", in_ready, 1'b0);
    step(0, 8'h00, 0, 0, 1);
    idle(1, 0);
    chk("t5_rdy_back", in_ready, 1'b1);
    chk("t5_level", level, 4);
    idle(10, 1);

    // Reset mid-operation
    for (int i = 0; i < 11; i++) step(1, 8'(i + 8'h70), 0, 0, 0);
    do_reset();
    step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0); step(1, 8'h04, 0, 0, 0);
    idle(1, 0);
    chk("t6_data", out_data, 32'h04030201);
    idle(2, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < ((i / 500) % 2 ? 3 : 8)));
    end
    idle(12, 1);
    chk("final_level", level, wq.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_pack_buffer.md
Name: byte_pack_buffer

Overview:
- Parametrised successor to the byte-write / word-read BRAM loader path.
- Accepts IN_W-bit bytes from an external loader on a valid/ready stream.
- Packs RATIO bytes per word with a run-time selectable byte order, and buffers words in an internal DEPTH-word FIFO.
- Presents words, with a byte-keep mask, on a first-word-fall-through valid/ready read port.
- Adds behaviour the fixed BRAM path lacks: back-pressure, explicit partial-word flush, and occupancy reporting.

Parameters:
- IN_W, 8, input byte width in bits.
- RATIO, 4, bytes per output word (power of 2, ≥ 2); OUT_W = IN_W*RATIO.
- ADDR_W, 9, FIFO address width; DEPTH = 2**ADDR_W words.

Ports:
- CLK_IN1  in  1  single clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte offered.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_data  in  IN_W  byte value.
- msb_first  in  1  byte order; sampled when the first byte of a word is accepted.
- flush  in  1  single-cycle pulse; push the partial word.
- out_valid  out  1  out_data/out_keep hold a word.
- out_ready  in  1  word consumed when out_valid && out_ready.
- out_data  out  OUT_W  packed word.
- out_keep  out  RATIO  bit k set = byte lane k carries real data.
- level  out  ADDR_W+1  words held, including the output register; range 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - idx=0, pack register=0, pointers=0, level=0, flush_pending=0.
  - out_valid=0, out_data=0, out_keep=0; in_ready=1.
  - Reset mid-word discards the partial word with no push.
- Packing:
  - idx counts bytes in the current word, 0..RATIO-1.
  - LSB-first: byte idx goes to lane idx, bits [idx*IN_W +: IN_W]. MSB-first: byte idx goes to lane RATIO-1-idx.
  - The byte-order mode is latched at idx=0 and held for the whole word. A msb_first change mid-word has no effect until the next word.
- Push: the byte accepted at idx=RATIO-1 completes the word. At that same edge the word is written with keep = all ones, idx returns to 0, and the pack register clears.
- in_ready = !flush_pending && (idx != RATIO-1 || level < DEPTH). in_ready is registered/derived from state only and never depends combinationally on out_ready.
- Flush:
  - flush with idx=0 and no byte accepted that cycle: ignored.
  - flush with idx>0: push the pack register, zero-padded, with keep set for the received lanes only (lanes mapped per the latched order).
  - A byte accepted in the same cycle is included first. If that byte completes the word, the normal push occurs and the flush is consumed with no extra push.
  - If level==DEPTH when a flush needs to push, set flush_pending and hold in_ready=0. Push as soon as level<DEPTH, then clear flush_pending.
- Output, first-word fall-through:
  - If the buffer is empty when a word is pushed at edge t, out_valid rises after edge t+1.
  - Thereafter, with out_ready held high, one word per cycle is delivered back-to-back with no bubbles.
  - out_data and out_keep are stable while out_valid && !out_ready.
- level:
  - +1 on push, −1 on pop; unchanged on a simultaneous push and pop.
  - A simultaneous push and pop at level==DEPTH is not allowed: the push is refused because in_ready was already low.
  - Pointers wrap modulo DEPTH.
- Storage: inferred single-clock RAM, OUT_W+RATIO bits wide (data plus keep), synchronous read.

Test Plan:
1. LSB-first, msb_first=0: bytes 11,22,33,44 → one word, out_data=0x44332211, out_keep=1111, out_valid rises 2 edges after byte 44 is accepted, level=1 until popped.
2. MSB-first, msb_first=1: bytes 11,22,33,44 → 0x11223344. Toggling msb_first after byte 11 still yields 0x11223344.
3. Partial flush: bytes AA,BB then flush (LSB-first) → out_data=0x0000BBAA, out_keep=0011. A second flush with idx=0 produces no word.
4. Full/back-pressure (ADDR_W=2, DEPTH=4): out_ready=0, stream 20 bytes → level=4, in_ready=0 at idx=3 of the 5th word. Raise out_ready for 1 cycle → one pop and one push, level stays 4, data order preserved.
5. Flush while full: level=4, idx=2, flush → flush_pending, in_ready=0. After one pop, partial word pushed with keep=0011 and in_ready returns to 1.
6. Reset mid-operation: RESET_N low with idx=3 and level=2 → immediately out_valid=0, level=0, in_ready=1. Next bytes 01,02,03,04 → 0x04030201 with no stale data.
